// File: rtl/accum_alu.sv
// Multi-operand accumulator: reduces a batch of COUNT operands by ADD or XOR over a
// valid/ready stream and holds one result, with sticky carry and parity, until it is accepted.
module accum_alu #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned COUNT = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_parity
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             carry, carry_nxt;
    logic             mode, mode_nxt;
    logic [WIDTH:0]   sum;
    logic             done;
    logic             beat;

    // Outputs decode the registered state; rst_n forces them low while reset is held.
    assign done       = rst_n && (state == DONE);
    assign in_ready   = rst_n && (state != DONE);
    assign out_valid  = done;
    assign out_data   = done ? acc : '0;
    assign out_carry  = done & carry;
    assign out_parity = done & (^acc);
    assign beat       = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            carry <= carry_nxt;
            mode  <= mode_nxt;
        end
    end

    // Next-state and datapath update; all state holds unless a beat or result accept occurs.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        carry_nxt = carry;
        mode_nxt  = mode;
        sum       = {1'b0, acc} + {1'b0, in_data};
        case (state)
            IDLE: begin
                if (beat) begin
                    acc_nxt   = in_data;
                    mode_nxt  = in_mode;
                    carry_nxt = 1'b0;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    if (mode) begin
                        acc_nxt = acc ^ in_data;
                    end else begin
                        acc_nxt   = sum[WIDTH-1:0];
                        carry_nxt = carry | sum[WIDTH];
                    end
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(COUNT - 1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
